// File: rtl/ahb_sram_slave.sv
// ============================================================================
// Module  : ahb_sram_slave
// Brief   : AHB-Lite word SRAM slave with programmable wait states, byte/half
//           lanes and a two-cycle ERROR response.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int         c_DEPTH     = 1 << ADDR_WIDTH;
  localparam logic       c_HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_wait_cnt;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [1:0]              r_size;
  logic [1:0]              r_off;
  logic                    r_write;
  logic [31:0]             r_mem [0:c_DEPTH-1];

  logic [31:0] w_off;
  logic        w_in_range;
  logic        w_misalign;
  logic        w_err;
  logic        w_accept;
  logic        w_load;
  logic [3:0]  w_be;
  logic        w_unused;

  assign w_unused = ^{HBURST, HTRANS[0]};

  // Offset relative to the base; anything with bits above the window is out of range.
  assign w_off      = HADDR - BASE_ADDR;
  assign w_in_range = (HADDR >= BASE_ADDR) && ((w_off >> (ADDR_WIDTH + 2)) == 32'd0);
  assign w_misalign = ((HSIZE == 3'b001) && HADDR[0]) ||
                      ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign w_err      = !w_in_range || (HSIZE > 3'b010) || w_misalign;
  assign w_accept   = HSEL && HREADY && HTRANS[1] && HREADYOUT;

  always_comb begin
    w_next    = r_state;
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    w_load    = 1'b0;
    case (r_state)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (r_wait_cnt == 4'd0) w_next = S_DATA;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
        w_next    = S_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all close the previous phase and may take a new address.
        if (r_state == S_ERR2) HRESP = 2'b01;
        w_next = S_IDLE;
        if (w_accept) begin
          if (w_err) begin
            w_next = S_ERR1;
          end else begin
            w_load = 1'b1;
            w_next = c_HAS_WAIT ? S_WAIT : S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_idx      <= '0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_write    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_wait_cnt <= c_WAIT_LOAD;
        r_idx      <= w_off[ADDR_WIDTH+1:2];
        r_size     <= HSIZE[1:0];
        r_off      <= HADDR[1:0];
        r_write    <= HWRITE;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      2'b00:   w_be = 4'b0001 << r_off;
      2'b01:   w_be = r_off[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && (r_state == S_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Asynchronous read makes a write in the previous data phase visible immediately.
  assign HRDATA = (r_state == S_DATA) ? r_mem[r_idx] : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
// ============================================================================
// Module  : tb_ahb_sram_slave
// Brief   : Directed vector bench for ahb_sram_slave (0 and 2 wait states).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel0, sel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] rdata0, rdata2;
  logic        rdy0, rdy2;
  logic [1:0]  resp0, resp2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.BASE_ADDR(32'h3800_0000), .ADDR_WIDTH(12), .WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy0), .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_sram_slave #(.BASE_ADDR(32'h3800_0000), .ADDR_WIDTH(12), .WAIT_STATES(2)) u_dut2 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(rdy2), .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2)
  );

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, S3 = 3'b011;
  localparam logic [31:0] A  = 32'h3800_1000;
  localparam logic [31:0] B  = 32'h3800_2000;
  localparam logic [31:0] Z  = 32'h3800_0000;

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    logic        rdy;
    logic [1:0]  resp;
    logic        crd;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] tr, logic wr, logic [2:0] sz, logic [31:0] ad,
                              logic [31:0] wd, logic rdy, logic [1:0] resp, logic crd,
                              logic [31:0] rd);
    vec_t v;
    v.tr = tr; v.wr = wr; v.sz = sz; v.ad = ad; v.wd = wd;
    v.rdy = rdy; v.resp = resp; v.crd = crd; v.rd = rd;
    return v;
  endfunction

  // One bus cycle: drive address/data phase inputs, check the selected slave, clock.
  task automatic step(input logic d2, input logic r, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                      input logic chk, input logic e_rdy, input logic [1:0] e_resp,
                      input logic crd, input logic [31:0] e_rd, input string nm);
    logic        a_rdy;
    logic [1:0]  a_resp;
    logic [31:0] a_rd;
    rst = r; sel0 = !d2; sel2 = d2;
    htrans = tr; hwrite = wr; hsize = sz; haddr = ad; hwdata = wd;
    #1;
    a_rdy  = d2 ? rdy2   : rdy0;
    a_resp = d2 ? resp2  : resp0;
    a_rd   = d2 ? rdata2 : rdata0;
    if (chk) begin
      n_tests++;
      if (a_rdy !== e_rdy || a_resp !== e_resp) begin
        n_fail++;
        $display("FAIL %s handshake: HREADYOUT=%0b HRESP=%0b, required HREADYOUT=%0b HRESP=%0b",
                 nm, a_rdy, a_resp, e_rdy, e_resp);
      end
    end
    if (crd) begin
      n_tests++;
      if (a_rd !== e_rd) begin
        n_fail++;
        $display("FAIL %s rdata: HRDATA=%08h, required %08h", nm, a_rd, e_rd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr2(input logic [31:0] ad, input logic [31:0] wd, input string nm);
    step(1'b1, 1'b0, NS,  1'b1, SW, ad, wd, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, {nm, "_adr"});
    step(1'b1, 1'b0, IDL, 1'b0, SW, ad, wd, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, {nm, "_w1"});
    step(1'b1, 1'b0, IDL, 1'b0, SW, ad, wd, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, {nm, "_w2"});
    step(1'b1, 1'b0, IDL, 1'b0, SW, ad, wd, 1'b1, 1'b1, 2'b00, 1'b0, 32'd0, {nm, "_dat"});
  endtask

  task automatic rd2(input logic [31:0] ad, input logic [31:0] exp, input string nm);
    step(1'b1, 1'b0, NS,  1'b0, SW, ad, 32'd0, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, {nm, "_adr"});
    step(1'b1, 1'b0, IDL, 1'b0, SW, ad, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, {nm, "_w1"});
    step(1'b1, 1'b0, IDL, 1'b0, SW, ad, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, {nm, "_w2"});
    step(1'b1, 1'b0, IDL, 1'b0, SW, ad, 32'd0, 1'b1, 1'b1, 2'b00, 1'b1, exp,   {nm, "_dat"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  ntr;
    logic [31:0] nad;
    hburst = 3'b001;
    // Reset with a live NONSEQ write on the bus.
    step(1'b0, 1'b1, NS, 1'b1, SW, A, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b00, 1'b0, 32'd0, "rst0");
    step(1'b0, 1'b1, NS, 1'b1, SW, A, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "rst1");
    step(1'b0, 1'b0, IDL, 1'b0, SW, A, 32'd0,       1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "rst2");

    //                  tr   wr    sz  addr          wdata          rdy   resp   crd   rdata
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'd0,         1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b1, SW, A,            32'd0,         1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b0, SW, A,            32'h0000_0001, 1'b1, 2'b00, 1'b0, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'd0,         1'b1, 2'b00, 1'b1, 32'h0000_0001));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'd0,         1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b1, SW, B,            32'd0,         1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b1, SB, B + 1,        32'hAABB_CCDD, 1'b1, 2'b00, 1'b0, 32'd0));
    tbl.push_back(mk(NS,  1'b1, SH, B + 2,        32'h0000_1100, 1'b1, 2'b00, 1'b0, 32'd0));
    tbl.push_back(mk(NS,  1'b0, SW, B,            32'h2233_0000, 1'b1, 2'b00, 1'b0, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, B,            32'd0,         1'b1, 2'b00, 1'b1, 32'h2233_11DD));
    tbl.push_back(mk(NS,  1'b1, SB, B + 3,        32'd0,         1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b1, SH, B,            32'h9900_0000, 1'b1, 2'b00, 1'b0, 32'd0));
    tbl.push_back(mk(NS,  1'b0, SW, B,            32'h0000_5566, 1'b1, 2'b00, 1'b0, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, B,            32'd0,         1'b1, 2'b00, 1'b1, 32'h9933_5566));
    tbl.push_back(mk(NS,  1'b1, SW, Z,            32'd0,         1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, Z,            32'h1234_5678, 1'b1, 2'b00, 1'b0, 32'd0));
    // Errors: out of range, misaligned, bad size, below base.
    tbl.push_back(mk(NS,  1'b1, SW, 32'h3800_4000, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'hFFFF_FFFF, 1'b0, 2'b01, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'hFFFF_FFFF, 1'b1, 2'b01, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b1, SW, A + 2,        32'hFFFF_FFFF, 1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'hFFFF_FFFF, 1'b0, 2'b01, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b1, S3, A,            32'hFFFF_FFFF, 1'b1, 2'b01, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'hFFFF_FFFF, 1'b0, 2'b01, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b0, SW, A,            32'hFFFF_FFFF, 1'b1, 2'b01, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'hFFFF_FFFF, 1'b1, 2'b00, 1'b1, 32'h0000_0001));
    tbl.push_back(mk(NS,  1'b0, SW, 32'h37FF_FFFC, 32'd0,        1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'd0,         1'b0, 2'b01, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, A,            32'd0,         1'b1, 2'b01, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b0, SW, Z,            32'd0,         1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(NS,  1'b0, SW, A,            32'd0,         1'b1, 2'b00, 1'b1, 32'h1234_5678));
    // BUSY inside a burst, then SEQ continues.
    tbl.push_back(mk(BSY, 1'b0, SW, A + 4,        32'd0,         1'b1, 2'b00, 1'b1, 32'h0000_0001));
    tbl.push_back(mk(SQ,  1'b0, SW, B,            32'd0,         1'b1, 2'b00, 1'b1, 32'd0));
    tbl.push_back(mk(IDL, 1'b0, SW, B,            32'd0,         1'b1, 2'b00, 1'b1, 32'h9933_5566));
    tbl.push_back(mk(IDL, 1'b0, SW, B,            32'd0,         1'b1, 2'b00, 1'b1, 32'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, 1'b0, tbl[i].tr, tbl[i].wr, tbl[i].sz, tbl[i].ad, tbl[i].wd, 1'b1,
           tbl[i].rdy, tbl[i].resp, tbl[i].crd, tbl[i].rd, $sformatf("vec%0d", i));
    end

    // Reset held over a NONSEQ write must not commit it.
    step(1'b0, 1'b1, NS, 1'b1, SW, A, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "rsth0");
    step(1'b0, 1'b1, NS, 1'b1, SW, A, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "rsth1");
    step(1'b0, 1'b0, NS, 1'b0, SW, A, 32'hDEAD_BEEF, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "rsth2");
    step(1'b0, 1'b0, IDL, 1'b0, SW, A, 32'd0,        1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0001, "rsth3");

    // Two wait states: preload 1..4, then a 4-beat INCR read.
    for (int k = 0; k < 4; k++) wr2(A + 32'(4 * k), 32'(k + 1), $sformatf("pre%0d", k));
    step(1'b1, 1'b0, NS, 1'b0, SW, A, 32'd0, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "burst_adr");
    for (int k = 0; k < 4; k++) begin
      ntr = (k < 3) ? SQ : IDL;
      nad = A + 32'(4 * (k + 1));
      step(1'b1, 1'b0, ntr, 1'b0, SW, nad, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0,
           $sformatf("beat%0d_w1", k));
      step(1'b1, 1'b0, ntr, 1'b0, SW, nad, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0,
           $sformatf("beat%0d_w2", k));
      step(1'b1, 1'b0, ntr, 1'b0, SW, nad, 32'd0, 1'b1, 1'b1, 2'b00, 1'b1, 32'(k + 1),
           $sformatf("beat%0d_dat", k));
    end

    // Reset during the wait phase of a write aborts it.
    step(1'b1, 1'b0, NS,  1'b1, SW, A, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "rstw_adr");
    step(1'b1, 1'b1, IDL, 1'b0, SW, A, 32'hCAFE_F00D, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, "rstw_w1");
    step(1'b1, 1'b0, IDL, 1'b0, SW, A, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "rstw_after");
    step(1'b1, 1'b0, IDL, 1'b0, SW, A, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b00, 1'b1, 32'd0, "rstw_idle");
    rd2(A, 32'h0000_0001, "rstw_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
